collision_scanner: RTL and testbench

COLLISION_SCANNER -- requirements
Module: collision_scanner

---
 rtl/collision_scanner_if.sv | 39 +++
 rtl/collision_scanner.sv | 137 +++++++++++++
 tb/tb_collision_scanner.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_scanner_if.sv
// Handshake and data bundle for the collision scanner: slot writes,
// player box, scan request and the result flags.
interface collision_scanner_if #(
   parameter int CW = 10,
   parameter int N  = 8,
   parameter int IW = $clog2(N)
);
   logic          start;
   logic [CW-1:0] p_x;
   logic [CW-1:0] p_y;
   logic [CW-1:0] p_w;
   logic [CW-1:0] p_h;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic          wr_valid;
   logic [CW-1:0] wr_x;
   logic [CW-1:0] wr_y;
   logic [CW-1:0] wr_w;
   logic [CW-1:0] wr_h;
   logic          busy;
   logic          done;
   logic          hit_any;
   logic [N-1:0]  hit_mask;
   logic [IW-1:0] first_idx;

   modport master (
      output start, p_x, p_y, p_w, p_h,
      output wr_en, wr_idx, wr_valid,
      output wr_x, wr_y, wr_w, wr_h,
      input  busy, done, hit_any, hit_mask, first_idx
   );

   modport slave (
      input  start, p_x, p_y, p_w, p_h,
      input  wr_en, wr_idx, wr_valid,
      input  wr_x, wr_y, wr_w, wr_h,
      output busy, done, hit_any, hit_mask, first_idx
   );
endinterface

// File: rtl/collision_scanner.sv
// Sequential box-overlap scanner: tests a latched player box against
// N object slots, one slot per clock, and reports the hit set.
module collision_scanner #(
   parameter int CW = 10,
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input logic clk,
   input logic reset,
   collision_scanner_if.slave bus
);
   localparam int SW = CW + 2;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic [N-1:0]  acc_q;
   logic [CW-1:0] px_q, py_q, pw_q, ph_q;

   logic [N-1:0]  valid_q;
   logic [CW-1:0] ox_q [N];
   logic [CW-1:0] oy_q [N];
   logic [CW-1:0] ow_q [N];
   logic [CW-1:0] oh_q [N];

   logic          done_q;
   logic          any_q;
   logic [N-1:0]  mask_q;
   logic [IW-1:0] first_q;

   logic          hit_d;
   logic [IW-1:0] first_d;

   // Strict 1-D overlap, widened and signed so edges never wrap.
   function automatic logic overlap(
      input logic [CW-1:0] pc,
      input logic [CW-1:0] ps,
      input logic [CW-1:0] oc,
      input logic [CW-1:0] os
   );
      logic signed [SW-1:0] p_lo, p_hi, o_lo, o_hi;
      p_lo = $signed({2'b00, pc}) - $signed({2'b00, ps >> 1});
      p_hi = $signed({2'b00, pc}) + $signed({2'b00, ps >> 1});
      o_lo = $signed({2'b00, oc}) - $signed({2'b00, os >> 1});
      o_hi = $signed({2'b00, oc}) + $signed({2'b00, os >> 1});
      return (p_hi > o_lo) && (p_lo < o_hi) &&
             (ps != '0) && (os != '0);
   endfunction

   always_comb begin
      hit_d = valid_q[idx_q] &&
              overlap(px_q, pw_q, ox_q[idx_q], ow_q[idx_q]) &&
              overlap(py_q, ph_q, oy_q[idx_q], oh_q[idx_q]);
   end

   always_comb begin
      first_d = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (acc_q[i]) first_d = IW'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (bus.wr_en) begin
         for (int i = 0; i < N; i++) begin
            if (int'(bus.wr_idx) == i) valid_q[i] <= bus.wr_valid;
         end
      end
   end

   // Geometry needs no reset: an invalid slot never hits.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         for (int i = 0; i < N; i++) begin
            if (int'(bus.wr_idx) == i) begin
               ox_q[i] <= bus.wr_x;
               oy_q[i] <= bus.wr_y;
               ow_q[i] <= bus.wr_w;
               oh_q[i] <= bus.wr_h;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         px_q    <= '0;
         py_q    <= '0;
         pw_q    <= '0;
         ph_q    <= '0;
         done_q  <= 1'b0;
         any_q   <= 1'b0;
         mask_q  <= '0;
         first_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  px_q    <= bus.p_x;
                  py_q    <= bus.p_y;
                  pw_q    <= bus.p_w;
                  ph_q    <= bus.p_h;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               acc_q[idx_q] <= hit_d;
               idx_q        <= idx_q + 1'b1;
               if (idx_q == IW'(N - 1)) state_q <= DONE;
            end
            DONE: begin
               mask_q  <= acc_q;
               any_q   <= |acc_q;
               first_q <= first_d;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.hit_any   = any_q;
   assign bus.hit_mask  = mask_q;
   assign bus.first_idx = first_q;
endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: table of single-slot scans plus
// hand sequences for mid-scan writes, ignored starts and reset abort.
module tb_collision_scanner;
   localparam int CW = 10;
   localparam int N  = 8;
   localparam int IW = $clog2(N);

   typedef struct {
      logic          v;
      logic [CW-1:0] x, y, w, h;
   } slot_t;

   typedef struct {
      logic [IW-1:0] idx;
      slot_t         s;
      logic [CW-1:0] px, py, pw, ph;
      logic [N-1:0]  exp;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [N-1:0] sb_q[$];
   logic [N-1:0]  ref_mask;
   logic          ref_any;
   logic [IW-1:0] ref_first;

   collision_scanner_if #(.CW(CW), .N(N), .IW(IW)) bus ();

   collision_scanner #(.CW(CW), .N(N), .IW(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IW-1:0] lowest(input logic [N-1:0] m);
      logic [IW-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) if (m[i]) r = IW'(i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every done pops one expected mask.
   always @(negedge clk) begin
      if (reset) begin
         ref_mask  = '0;
         ref_any   = 1'b0;
         ref_first = '0;
      end else if (bus.done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
         end else begin
            ref_mask  = sb_q.pop_front();
            ref_any   = |ref_mask;
            ref_first = lowest(ref_mask);
            chk("hit_mask", 32'(bus.hit_mask), 32'(ref_mask));
            chk("hit_any", 32'(bus.hit_any), 32'(ref_any));
            chk("first_idx", 32'(bus.first_idx), 32'(ref_first));
            chk("busy_at_done", 32'(bus.busy), 32'd0);
         end
      end else begin
         chk("hold_mask", 32'(bus.hit_mask), 32'(ref_mask));
         chk("hold_any", 32'(bus.hit_any), 32'(ref_any));
         chk("hold_first", 32'(bus.first_idx), 32'(ref_first));
      end
   end

   task automatic write_slot(input logic [IW-1:0] i, input slot_t s);
      bus.wr_en    = 1'b1;
      bus.wr_idx   = i;
      bus.wr_valid = s.v;
      bus.wr_x     = s.x;
      bus.wr_y     = s.y;
      bus.wr_w     = s.w;
      bus.wr_h     = s.h;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic clear_slots();
      slot_t z;
      z = '{1'b0, 10'd0, 10'd0, 10'd0, 10'd0};
      for (int i = 0; i < N; i++) write_slot(IW'(i), z);
   endtask

   task automatic run_scan(
      input logic [CW-1:0] px, input logic [CW-1:0] py,
      input logic [CW-1:0] pw, input logic [CW-1:0] ph,
      input logic [N-1:0] exp, input int mid_k,
      input logic [IW-1:0] mid_i, input slot_t mid_s,
      input bit disturb
   );
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = 0;
      sb_q.push_back(exp);
      bus.p_x   = px;
      bus.p_y   = py;
      bus.p_w   = pw;
      bus.p_h   = ph;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (disturb) begin
         bus.p_x   = 10'd500;
         bus.p_y   = 10'd500;
         bus.start = 1'b1;
      end
      for (int k = 0; k < 40 && !seen; k++) begin
         if (k == mid_k) begin
            bus.wr_en    = 1'b1;
            bus.wr_idx   = mid_i;
            bus.wr_valid = mid_s.v;
            bus.wr_x     = mid_s.x;
            bus.wr_y     = mid_s.y;
            bus.wr_w     = mid_s.w;
            bus.wr_h     = mid_s.h;
         end
         @(negedge clk);
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
         if (k == N - 1) chk("busy_before_done", 32'(bus.busy), 32'd1);
         if (bus.done) begin
            seen = 1'b1;
            lat  = k + 1;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done");
         void'(sb_q.pop_front());
      end else begin
         chk("latency", 32'(lat), 32'(N + 1));
      end
   endtask

   vec_t  tbl[13];
   slot_t nos;
   slot_t hit_s;

   initial begin
      checks = 0;
      errors = 0;
      ref_mask  = '0;
      ref_any   = 1'b0;
      ref_first = '0;
      nos   = '{1'b0, 10'd0, 10'd0, 10'd0, 10'd0};
      hit_s = '{1'b1, 10'd100, 10'd100, 10'd20, 10'd20};

      tbl[0]  = '{3, '{1, 100, 100, 20, 20}, 105, 105, 10, 10, 8'h08};
      tbl[1]  = '{0, '{1, 130, 100, 20, 20}, 110, 100, 20, 20, 8'h00};
      tbl[2]  = '{1, '{1, 1020, 2, 10, 10}, 2, 2, 10, 10, 8'h00};
      tbl[3]  = '{2, '{1, 0, 0, 4, 4}, 2, 2, 10, 10, 8'h04};
      tbl[4]  = '{7, '{0, 100, 100, 20, 20}, 100, 100, 10, 10, 8'h00};
      tbl[5]  = '{6, '{1, 100, 100, 0, 20}, 100, 100, 10, 10, 8'h00};
      tbl[6]  = '{4, '{1, 100, 100, 20, 20}, 100, 100, 0, 0, 8'h00};
      tbl[7]  = '{7, '{1, 100, 120, 20, 20}, 100, 100, 20, 20, 8'h00};
      tbl[8]  = '{7, '{1, 100, 119, 20, 20}, 100, 100, 20, 20, 8'h80};
      tbl[9]  = '{5, '{1, 54, 50, 5, 5}, 50, 50, 5, 5, 8'h00};
      tbl[10] = '{5, '{1, 53, 50, 5, 5}, 50, 50, 5, 5, 8'h20};
      tbl[11] = '{0, '{1, 0, 0, 4, 4}, 1023, 1023, 4, 4, 8'h00};
      tbl[12] = '{0, '{1, 1023, 1023, 2, 2}, 1023, 1023, 4, 4, 8'h01};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.p_x   = '0;
      bus.p_y   = '0;
      bus.p_w   = '0;
      bus.p_h   = '0;
      bus.wr_en = 1'b0;
      bus.wr_idx   = '0;
      bus.wr_valid = 1'b0;
      bus.wr_x = '0;
      bus.wr_y = '0;
      bus.wr_w = '0;
      bus.wr_h = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_any", 32'(bus.hit_any), 32'd0);
      chk("rst_mask", 32'(bus.hit_mask), 32'd0);
      chk("rst_first", 32'(bus.first_idx), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      foreach (tbl[v]) begin
         clear_slots();
         write_slot(tbl[v].idx, tbl[v].s);
         run_scan(tbl[v].px, tbl[v].py, tbl[v].pw, tbl[v].ph,
                  tbl[v].exp, -1, '0, nos, 1'b0);
         @(negedge clk);
      end

      // Slot 5 enabled mid-scan; second start and player change ignored.
      clear_slots();
      write_slot(3'd2, hit_s);
      write_slot(3'd5, '{1'b0, 10'd100, 10'd100, 10'd20, 10'd20});
      run_scan(10'd100, 10'd100, 10'd10, 10'd10, 8'h24, 1, 3'd5,
               hit_s, 1'b1);
      repeat (4) @(negedge clk);
      chk("no_queued_start", 32'(bus.busy), 32'd0);

      // Write to the slot under evaluation sees the old value.
      clear_slots();
      write_slot(3'd3, hit_s);
      run_scan(10'd100, 10'd100, 10'd10, 10'd10, 8'h08, 3, 3'd3,
               '{1'b0, 10'd100, 10'd100, 10'd20, 10'd20}, 1'b0);
      @(negedge clk);
      run_scan(10'd100, 10'd100, 10'd10, 10'd10, 8'h00, -1, '0,
               nos, 1'b0);
      @(negedge clk);

      // Reset during scan aborts with outputs cleared.
      clear_slots();
      write_slot(3'd2, hit_s);
      run_scan(10'd100, 10'd100, 10'd10, 10'd10, 8'h04, -1, '0,
               nos, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_mask", 32'(bus.hit_mask), 32'd0);
      chk("abort_any", 32'(bus.hit_any), 32'd0);
      chk("abort_first", 32'(bus.first_idx), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      run_scan(10'd100, 10'd100, 10'd10, 10'd10, 8'h00, -1, '0,
               nos, 1'b0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
